// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t DIGIT_MAX    = 4'd9;

  // True when a packed {tens,ones} BCD byte has tens <= tens_max and ones <= 9.
  function automatic logic bcd_byte_valid(input logic [7:0] b, input bcd_digit_t tens_max);
    return (b[7:4] <= tens_max) && (b[3:0] <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a down-counter: decrements when borrow_in is set,
// wrapping 0 -> max_val and passing a borrow to the next digit.
module bcd_digit_dec
  import timer_pkg::*;
(
  input  bcd_digit_t digit_in,
  input  bcd_digit_t max_val,
  input  logic       borrow_in,
  output bcd_digit_t digit_out,
  output logic       borrow_out
);

  // Decrement with wrap-around; the digit passes through untouched without a borrow.
  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = max_val;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/pause control, a 1 Hz tick
// edge detector and optional auto-reload on expiry.
module countdown_timer
  import timer_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       ar,
  input  logic       tick_in,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] preset_mm,
  input  logic [7:0] preset_ss,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  state_e     state_q, state_d;
  bcd_digit_t min_t_q, min_t_d, min_o_q, min_o_d;
  bcd_digit_t sec_t_q, sec_t_d, sec_o_q, sec_o_d;
  logic [7:0] rl_mm_q, rl_mm_d, rl_ss_q, rl_ss_d;
  logic       running_q, running_d, expired_q, expired_d;
  logic       done_q, done_d, load_err_q, load_err_d;
  logic       tick_d_q, tick_armed_q;
  logic       sec_evt, preset_ok, count_zero, next_zero;

  bcd_digit_t so_nx, st_nx, mo_nx, mt_nx;
  logic       so_b, st_b, mo_b, mt_b;

  // The armed flag needs tick_in to be seen low after reset, so a tick that is
  // already high when reset releases is not mistaken for a fresh rising edge.
  assign sec_evt   = tick_in & ~tick_d_q & tick_armed_q;
  assign preset_ok = bcd_byte_valid(preset_mm, DIGIT_MAX) &&
                     bcd_byte_valid(preset_ss, SEC_TENS_MAX);

  bcd_digit_dec u_sec_o (.digit_in(sec_o_q), .max_val(DIGIT_MAX),    .borrow_in(1'b1),
                         .digit_out(so_nx),   .borrow_out(so_b));
  bcd_digit_dec u_sec_t (.digit_in(sec_t_q), .max_val(SEC_TENS_MAX), .borrow_in(so_b),
                         .digit_out(st_nx),   .borrow_out(st_b));
  bcd_digit_dec u_min_o (.digit_in(min_o_q), .max_val(DIGIT_MAX),    .borrow_in(st_b),
                         .digit_out(mo_nx),   .borrow_out(mo_b));
  bcd_digit_dec u_min_t (.digit_in(min_t_q), .max_val(DIGIT_MAX),    .borrow_in(mo_b),
                         .digit_out(mt_nx),   .borrow_out(mt_b));

  // A borrow ripples out of the top digit only when every digit is zero.
  assign count_zero = mt_b;
  assign next_zero  = ({mt_nx, mo_nx, st_nx, so_nx} == 16'h0000);

  // Next-state logic: load beats pause beats start beats a second event.
  always_comb begin
    state_d    = state_q;
    min_t_d    = min_t_q;
    min_o_d    = min_o_q;
    sec_t_d    = sec_t_q;
    sec_o_d    = sec_o_q;
    rl_mm_d    = rl_mm_q;
    rl_ss_d    = rl_ss_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (preset_ok) begin
        min_t_d = preset_mm[7:4];
        min_o_d = preset_mm[3:0];
        sec_t_d = preset_ss[7:4];
        sec_o_d = preset_ss[3:0];
        rl_mm_d = preset_mm;
        rl_ss_d = preset_ss;
        state_d = ST_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pause) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSED;
      end
    end else if (start) begin
      if (state_q == ST_IDLE || state_q == ST_PAUSED) begin
        if (count_zero) begin
          state_d = ST_EXPIRED;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end else if (state_q == ST_RUN && sec_evt && !count_zero) begin
      min_t_d = mt_nx;
      min_o_d = mo_nx;
      sec_t_d = st_nx;
      sec_o_d = so_nx;
      if (next_zero) begin
        done_d = 1'b1;
        if (AUTO_RELOAD && ({rl_mm_q, rl_ss_q} != 16'h0000)) begin
          min_t_d = rl_mm_q[7:4];
          min_o_d = rl_mm_q[3:0];
          sec_t_d = rl_ss_q[7:4];
          sec_o_d = rl_ss_q[3:0];
        end else begin
          state_d = ST_EXPIRED;
        end
      end
    end
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // State, digit, reload and output registers; reset aborts everything at once.
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state_q      <= ST_IDLE;
      min_t_q      <= '0;
      min_o_q      <= '0;
      sec_t_q      <= '0;
      sec_o_q      <= '0;
      rl_mm_q      <= '0;
      rl_ss_q      <= '0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
      done_q       <= 1'b0;
      load_err_q   <= 1'b0;
      tick_d_q     <= 1'b0;
      tick_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_t_q      <= min_t_d;
      min_o_q      <= min_o_d;
      sec_t_q      <= sec_t_d;
      sec_o_q      <= sec_o_d;
      rl_mm_q      <= rl_mm_d;
      rl_ss_q      <= rl_ss_d;
      running_q    <= running_d;
      expired_q    <= expired_d;
      done_q       <= done_d;
      load_err_q   <= load_err_d;
      tick_d_q     <= tick_in;
      tick_armed_q <= tick_armed_q | ~tick_in;
    end
  end

  assign min_t    = min_t_q;
  assign min_o    = min_o_q;
  assign sec_t    = sec_t_q;
  assign sec_o    = sec_o_q;
  assign running  = running_q;
  assign done     = done_q;
  assign expired  = expired_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: one plain instance and one with
// AUTO_RELOAD=1, both driven by the same stimulus.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       ar, tick_in, load, start, pause;
  logic [7:0] preset_mm, preset_ss;

  logic [3:0] d0_min_t, d0_min_o, d0_sec_t, d0_sec_o;
  logic       d0_running, d0_done, d0_expired, d0_load_err;
  logic [3:0] d1_min_t, d1_min_o, d1_sec_t, d1_sec_o;
  logic       d1_running, d1_done, d1_expired, d1_load_err;

  logic [18:0] obs0, obs1, exp_v;
  logic [18:0] sb_q[$];
  int          total = 0;
  int          bad   = 0;

  countdown_timer #(.AUTO_RELOAD(1'b0)) u_dut0 (
    .clk(clk), .ar(ar), .tick_in(tick_in), .load(load), .start(start), .pause(pause),
    .preset_mm(preset_mm), .preset_ss(preset_ss),
    .min_t(d0_min_t), .min_o(d0_min_o), .sec_t(d0_sec_t), .sec_o(d0_sec_o),
    .running(d0_running), .done(d0_done), .expired(d0_expired), .load_err(d0_load_err)
  );

  countdown_timer #(.AUTO_RELOAD(1'b1)) u_dut1 (
    .clk(clk), .ar(ar), .tick_in(tick_in), .load(load), .start(start), .pause(pause),
    .preset_mm(preset_mm), .preset_ss(preset_ss),
    .min_t(d1_min_t), .min_o(d1_min_o), .sec_t(d1_sec_t), .sec_o(d1_sec_o),
    .running(d1_running), .done(d1_done), .expired(d1_expired), .load_err(d1_load_err)
  );

  always #5 clk = ~clk;

  assign obs0 = {d0_min_t, d0_min_o, d0_sec_t, d0_sec_o, d0_running, d0_done, d0_expired};
  assign obs1 = {d1_min_t, d1_min_o, d1_sec_t, d1_sec_o, d1_running, d1_done, d1_expired};

  // Binary seconds to packed BCD mm:ss, independent of the DUT's borrow chain.
  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [18:0] snap(input int secs, input logic run, input logic dn, input logic ex);
    return {to_bcd(secs), run, dn, ex};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] mm, input logic [7:0] ss);
    preset_mm = mm;
    preset_ss = ss;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    step();
    pause = 1'b0;
  endtask

  task automatic tick_rise();
    tick_in = 1'b1;
    step();
  endtask

  task automatic tick_fall();
    step();
    tick_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    ar = 1'b1; tick_in = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    preset_mm = 8'h00; preset_ss = 8'h00;
    step(); step();
    total++;
    if (obs0 !== 19'h0) begin bad++; $display("[TB] FAIL reset_obs0: got %h want %h", obs0, 19'h0); end
    total++;
    if (obs1 !== 19'h0) begin bad++; $display("[TB] FAIL reset_obs1: got %h want %h", obs1, 19'h0); end
    total++;
    if (d0_load_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_load_err: got %b want 0", d0_load_err); end
    ar = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int secs;
    pulse_load(8'h00, 8'h03);
    total++;
    if (obs0 !== snap(3, 0, 0, 0)) begin bad++; $display("[TB] FAIL basic_load: got %h want %h", obs0, snap(3, 0, 0, 0)); end
    pulse_start();
    total++;
    if (obs0 !== snap(3, 1, 0, 0)) begin bad++; $display("[TB] FAIL basic_start: got %h want %h", obs0, snap(3, 1, 0, 0)); end
    secs = 3;
    for (int i = 0; i < 3; i++) begin
      secs--;
      sb_q.push_back(snap(secs, secs != 0, secs == 0, secs == 0));
      tick_rise();
      exp_v = sb_q.pop_front();
      total++;
      if (obs0 !== exp_v) begin bad++; $display("[TB] FAIL basic_tick%0d: got %h want %h", i, obs0, exp_v); end
      step();
      total++;
      if (d0_done !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_width%0d: got %b want 0", i, d0_done); end
      tick_in = 1'b0;
      step();
    end
    total++;
    if (obs0 !== snap(0, 0, 0, 1)) begin bad++; $display("[TB] FAIL basic_expired: got %h want %h", obs0, snap(0, 0, 0, 1)); end
    pulse_start();
    total++;
    if (obs0 !== snap(0, 0, 0, 1)) begin bad++; $display("[TB] FAIL basic_start_in_expired: got %h want %h", obs0, snap(0, 0, 0, 1)); end
  endtask

  task automatic test_borrow();
    pulse_load(8'h10, 8'h00);
    pulse_start();
    sb_q.push_back(snap(599, 1, 0, 0));
    tick_rise();
    exp_v = sb_q.pop_front();
    total++;
    if (obs0 !== exp_v) begin bad++; $display("[TB] FAIL borrow_chain: got %h want %h", obs0, exp_v); end
    tick_fall();
    pulse_load(8'h00, 8'h00);
    total++;
    if (obs0 !== snap(0, 0, 0, 0)) begin bad++; $display("[TB] FAIL zero_load: got %h want %h", obs0, snap(0, 0, 0, 0)); end
    pulse_start();
    total++;
    if (obs0 !== snap(0, 0, 1, 1)) begin bad++; $display("[TB] FAIL zero_start: got %h want %h", obs0, snap(0, 0, 1, 1)); end
    step();
    total++;
    if (obs0 !== snap(0, 0, 0, 1)) begin bad++; $display("[TB] FAIL zero_start_after: got %h want %h", obs0, snap(0, 0, 0, 1)); end
  endtask

  task automatic test_pause();
    pulse_load(8'h00, 8'h05);
    pulse_start();
    sb_q.push_back(snap(4, 1, 0, 0));
    tick_rise();
    exp_v = sb_q.pop_front();
    total++;
    if (obs0 !== exp_v) begin bad++; $display("[TB] FAIL pause_first_tick: got %h want %h", obs0, exp_v); end
    tick_fall();
    pulse_pause();
    total++;
    if (obs0 !== snap(4, 0, 0, 0)) begin bad++; $display("[TB] FAIL pause_enter: got %h want %h", obs0, snap(4, 0, 0, 0)); end
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(snap(4, 0, 0, 0));
      tick_rise();
      exp_v = sb_q.pop_front();
      total++;
      if (obs0 !== exp_v) begin bad++; $display("[TB] FAIL pause_hold%0d: got %h want %h", i, obs0, exp_v); end
      tick_fall();
    end
    pulse_start();
    total++;
    if (obs0 !== snap(4, 1, 0, 0)) begin bad++; $display("[TB] FAIL pause_resume: got %h want %h", obs0, snap(4, 1, 0, 0)); end
    sb_q.push_back(snap(3, 1, 0, 0));
    tick_rise();
    exp_v = sb_q.pop_front();
    total++;
    if (obs0 !== exp_v) begin bad++; $display("[TB] FAIL pause_after_resume: got %h want %h", obs0, exp_v); end
    tick_fall();
  endtask

  task automatic test_load_err();
    logic [7:0] bad_ss [2];
    bad_ss[0] = 8'h5A;
    bad_ss[1] = 8'h60;
    for (int i = 0; i < 2; i++) begin
      pulse_load(8'h00, bad_ss[i]);
      total++;
      if (d0_load_err !== 1'b1 || d1_load_err !== 1'b1) begin
        bad++; $display("[TB] FAIL load_err_pulse%0d: got %b%b want 11", i, d0_load_err, d1_load_err);
      end
      total++;
      if (obs0 !== snap(3, 1, 0, 0)) begin bad++; $display("[TB] FAIL load_err_keep%0d: got %h want %h", i, obs0, snap(3, 1, 0, 0)); end
      step();
      total++;
      if (d0_load_err !== 1'b0) begin bad++; $display("[TB] FAIL load_err_width%0d: got %b want 0", i, d0_load_err); end
    end
  endtask

  task automatic test_auto_reload();
    int secs;
    int dones;
    logic dn;
    pulse_load(8'h00, 8'h02);
    pulse_start();
    secs  = 2;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      secs--;
      dn = 1'b0;
      if (secs == 0) begin
        secs = 2;
        dn   = 1'b1;
      end
      sb_q.push_back(snap(secs, 1, dn, 0));
      tick_rise();
      exp_v = sb_q.pop_front();
      if (d1_done === 1'b1) dones++;
      total++;
      if (obs1 !== exp_v) begin bad++; $display("[TB] FAIL auto_tick%0d: got %h want %h", i, obs1, exp_v); end
      step();
      if (d1_done === 1'b1) dones++;
      tick_in = 1'b0;
      step();
    end
    total++;
    if (dones !== 2) begin bad++; $display("[TB] FAIL auto_done_count: got %0d want 2", dones); end
    total++;
    if (d1_expired !== 1'b0) begin bad++; $display("[TB] FAIL auto_expired: got %b want 0", d1_expired); end
    total++;
    if (obs0 !== snap(0, 0, 0, 1)) begin bad++; $display("[TB] FAIL noauto_expired: got %h want %h", obs0, snap(0, 0, 0, 1)); end
  endtask

  task automatic test_reset_mid();
    pulse_load(8'h00, 8'h05);
    pulse_start();
    sb_q.push_back(snap(4, 1, 0, 0));
    tick_rise();
    exp_v = sb_q.pop_front();
    total++;
    if (obs0 !== exp_v) begin bad++; $display("[TB] FAIL mid_pre: got %h want %h", obs0, exp_v); end
    tick_in = 1'b0;
    step();
    ar = 1'b1;
    #1;
    total++;
    if (obs0 !== 19'h0 || d0_load_err !== 1'b0) begin bad++; $display("[TB] FAIL mid_async: got %h want %h", obs0, 19'h0); end
    step();
    total++;
    if (obs0 !== 19'h0) begin bad++; $display("[TB] FAIL mid_held: got %h want %h", obs0, 19'h0); end
    ar = 1'b0;
    step();
    total++;
    if (d0_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_done: got %b want 0", d0_done); end
    preset_mm = 8'h00;
    preset_ss = 8'h07;
    load  = 1'b1;
    start = 1'b1;
    step();
    load  = 1'b0;
    start = 1'b0;
    total++;
    if (obs0 !== snap(7, 0, 0, 0)) begin bad++; $display("[TB] FAIL load_beats_start: got %h want %h", obs0, snap(7, 0, 0, 0)); end
    sb_q.push_back(snap(7, 0, 0, 0));
    tick_rise();
    exp_v = sb_q.pop_front();
    total++;
    if (obs0 !== exp_v) begin bad++; $display("[TB] FAIL idle_tick: got %h want %h", obs0, exp_v); end
    tick_fall();
  endtask

  task automatic test_back_to_back();
    pulse_start();
    sb_q.push_back(snap(6, 1, 0, 0));
    tick_rise();
    exp_v = sb_q.pop_front();
    total++;
    if (obs0 !== exp_v) begin bad++; $display("[TB] FAIL b2b_tick: got %h want %h", obs0, exp_v); end
    tick_fall();
    pause = 1'b1;
    start = 1'b1;
    step();
    pause = 1'b0;
    start = 1'b0;
    total++;
    if (obs0 !== snap(6, 0, 0, 0)) begin bad++; $display("[TB] FAIL pause_beats_start: got %h want %h", obs0, snap(6, 0, 0, 0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_load_err();
    test_auto_reload();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter AUTO_RELOAD, default 0: when 1, expiry reloads the last preset and keeps running.
REQ-002 clk  input  1  system clock (50 MHz); all state updates on its rising edge.
REQ-003 ar  input  1  reset, asynchronous, active-high.
REQ-004 tick_in  input  1  divided 1 Hz square wave from the clock divider, synchronous to clk.
REQ-005 load  input  1  single-cycle pulse: capture preset_mm/preset_ss.
REQ-006 start  input  1  single-cycle pulse: begin or resume counting.
REQ-007 pause  input  1  single-cycle pulse: hold count.
REQ-008 preset_mm  input  8  BCD minutes {tens,ones}, valid 00-99.
REQ-009 preset_ss  input  8  BCD seconds {tens,ones}, valid 00-59.
REQ-010 min_t, min_o, sec_t, sec_o  output  4 each  current BCD digits.
REQ-011 running  output  1  high in RUN.
REQ-012 done  output  1  one-cycle pulse on expiry.
REQ-013 expired  output  1  level, high in EXPIRED.
REQ-014 load_err  output  1  one-cycle pulse when a load is rejected as non-BCD.

Function
REQ-015 States: IDLE, RUN, PAUSED, EXPIRED; encoding is registered.
REQ-016 Second event: tick_d registers tick_in; sec_evt = tick_in & ~tick_d (rising edge only); falling edges ignored.
REQ-017 load in any state: if valid, digits and the reload register take the preset and the state becomes IDLE the next cycle.
REQ-018 Invalid load: any digit >9 or sec_t >5 leaves digits and state unchanged and pulses load_err.
REQ-019 Priority when inputs coincide in one cycle: load > pause > start; lower-priority inputs in that cycle are ignored.
REQ-020 start in IDLE or PAUSED: digits nonzero -> RUN; digits 00:00 -> EXPIRED with done pulsed.
REQ-021 start in RUN or EXPIRED is ignored.
REQ-022 pause in RUN -> PAUSED; ignored in all other states.
REQ-023 In RUN, each sec_evt decrements mm:ss by one second in BCD, updating on the same clk edge that sees sec_evt.
REQ-024 Borrow chain: sec_o 0->9 with borrow; sec_t 0->5 with borrow; min_o 0->9 with borrow; min_t decrements.
REQ-025 The decrement that produces 00:00 sets EXPIRED and pulses done on that same edge.
REQ-026 With AUTO_RELOAD=1, that same edge instead loads the reload register and stays in RUN (done still pulses).
REQ-027 With AUTO_RELOAD=1 and reload value 00:00, the block goes to EXPIRED.
REQ-028 sec_evt outside RUN has no effect; tick_in edges are never queued.
REQ-029 The count never wraps below 00:00.
REQ-030 All outputs are registered; zero combinational paths from inputs to outputs.

Reset
REQ-031 While ar=1: state=IDLE, all digits 0, reload register 0, tick_d=0.
REQ-032 While ar=1: running=0, done=0, expired=0, load_err=0.
REQ-033 Reset asserted mid-count aborts immediately, with no done pulse.
REQ-034 After ar deasserts, a tick_in already high does not generate sec_evt until its next rising edge.

Structure
REQ-035 Shared package timer_pkg holds the state enum, the BCD digit type, and constants SEC_TENS_MAX=5 and DIGIT_MAX=9.
REQ-036 One sub-module, bcd_digit_dec (digit in, max value, borrow in -> digit out, borrow out), is instantiated four times.
REQ-037 The FSM and edge detector live in the top module.

Verification
REQ-038 Load 00:03, start, 3 tick_in rising edges -> digits 00:02, 00:01, 00:00; done high exactly one cycle on the 3rd; expired=1.
REQ-039 Load 10:00, start, 1 tick -> 09:59 (full borrow chain).
REQ-040 Load 00:05, start, 1 tick, pause, 2 ticks, start, 1 tick -> 00:03; running low during pause.
REQ-041 Load 00:5A, and load 00:60 -> load_err pulses each time, digits unchanged.
REQ-042 AUTO_RELOAD=1, load 00:02, start, 4 ticks -> digits 00:01, 00:02, 00:01, 00:02; done pulsed twice; expired stays 0.
REQ-043 Assert ar mid-count at 00:04 -> all outputs 0, state IDLE, no done; load and start in the same cycle -> load wins, state IDLE.
